// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC bus master slice.
// Flits are {last, data[7:0]}; processor ids are PROC_ID_W bits wide.
package noc_pkg;

    localparam int FLIT_W    = 9;
    localparam int LAST_BIT  = 8;
    localparam int PROC_ID_W = 2;

    // Flit injected toward the destination when a burst is aborted
    localparam logic [FLIT_W-1:0] FORCED_LAST_FLIT = 9'h100;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        STREAM,
        RELEASE
    } state_t;

    // True when a flit closes its burst
    function automatic logic is_last_flit(input logic [FLIT_W-1:0] flit);
        return flit[LAST_BIT];
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just above the
// pointer and wraps, so the port that was last served has lowest priority.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int N_PROC = 4
) (
    input  logic [N_PROC-1:0]    request,
    input  logic [PROC_ID_W-1:0] ptr,
    output logic [N_PROC-1:0]    grant,
    output logic [PROC_ID_W-1:0] grant_idx,
    output logic                 grant_valid
);

    // Walk candidates ptr+1, ptr+2, ... (mod N_PROC) and take the first requester
    always_comb begin
        int cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int k = 1; k <= N_PROC; k++) begin
            cand = (int'(ptr) + k) % N_PROC;
            for (int j = 0; j < N_PROC; j++) begin
                if (!grant_valid && (j == cand) && request[j]) begin
                    grant_valid = 1'b1;
                    grant[j]    = 1'b1;
                    grant_idx   = PROC_ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/noc_master_arbiter.sv
// NoC bus master: round-robin grant of one processor at a time, then a
// 1-cycle-latency route of its flit stream to the chosen destination.
// Optional feature macro: NOC_MASTER_TIMEOUT_EN aborts a burst that has
// gone TIMEOUT_CYC STREAM cycles without a last flit.
// HOLDOFF is expected to be at least 1.
module noc_master_arbiter
    import noc_pkg::*;
#(
    parameter int N_PROC      = 4,
    parameter int HOLDOFF     = 2,
    parameter int TIMEOUT_CYC = 300
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_PROC-1:0]             request_transfer,
    input  logic [PROC_ID_W*N_PROC-1:0]   which_processor,
    input  logic [FLIT_W*N_PROC-1:0]      data_to_router,
    output logic [N_PROC-1:0]             master_response,
    output logic [FLIT_W*N_PROC-1:0]      data_from_router,
    output logic                          busy,
    output logic [PROC_ID_W-1:0]          cur_src,
    output logic [PROC_ID_W-1:0]          cur_dst,
    output logic                          timeout_err
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_t                      state, state_n;
    logic [PROC_ID_W-1:0]        ptr, ptr_n;
    logic [PROC_ID_W-1:0]        src_n, dst_n;
    logic [N_PROC-1:0]           resp_n;
    logic [FLIT_W*N_PROC-1:0]    dfr_n;
    logic                        busy_n;
    logic [HOLD_W-1:0]           hold_cnt, hold_n;

    logic [N_PROC-1:0]           arb_grant;
    logic [PROC_ID_W-1:0]        arb_idx;
    logic                        arb_valid;

    logic [FLIT_W-1:0]           src_flit;
    logic [PROC_ID_W-1:0]        req_dst;

`ifdef NOC_MASTER_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [TCNT_W-1:0]           tcnt, tcnt_n;
    logic                        terr_n;
`else
    logic                        unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout_err        = 1'b0;
`endif

    noc_rr_arbiter #(
        .N_PROC (N_PROC)
    ) u_rr (
        .request     (request_transfer),
        .ptr         (ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Select the current source's flit from the packed input bus
    always_comb begin
        src_flit = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (cur_src == PROC_ID_W'(i)) begin
                src_flit = data_to_router[FLIT_W*i +: FLIT_W];
            end
        end
    end

    // Destination id requested by the arbitration winner
    always_comb begin
        req_dst = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (arb_idx == PROC_ID_W'(i)) begin
                req_dst = which_processor[PROC_ID_W*i +: PROC_ID_W];
            end
        end
    end

    // Next-state and next-output logic; every output is registered from these
    always_comb begin
        logic [FLIT_W-1:0] flit_out;
        logic              burst_end;
        state_n   = state;
        ptr_n     = ptr;
        src_n     = cur_src;
        dst_n     = cur_dst;
        resp_n    = '0;
        dfr_n     = '0;
        busy_n    = busy;
        hold_n    = hold_cnt;
        flit_out  = src_flit;
        burst_end = is_last_flit(src_flit);
`ifdef NOC_MASTER_TIMEOUT_EN
        tcnt_n    = tcnt;
        terr_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (arb_valid) begin
                    state_n = GRANT;
                    src_n   = arb_idx;
                    dst_n   = req_dst;
                    resp_n  = arb_grant;
                    busy_n  = 1'b1;
                end
            end
            GRANT: begin
                state_n = STREAM;
`ifdef NOC_MASTER_TIMEOUT_EN
                tcnt_n  = '0;
`endif
            end
            STREAM: begin
`ifdef NOC_MASTER_TIMEOUT_EN
                if (!burst_end) begin
                    if (tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
                        flit_out  = FORCED_LAST_FLIT;
                        burst_end = 1'b1;
                        terr_n    = 1'b1;
                    end else begin
                        tcnt_n = tcnt + TCNT_W'(1);
                    end
                end
`endif
                // Destinations outside 0..N_PROC-1 match no slot and are dropped
                for (int i = 0; i < N_PROC; i++) begin
                    if (cur_dst == PROC_ID_W'(i)) begin
                        dfr_n[FLIT_W*i +: FLIT_W] = flit_out;
                    end
                end
                if (burst_end) begin
                    state_n = RELEASE;
                    ptr_n   = cur_src;
                    hold_n  = '0;
                end
            end
            RELEASE: begin
                if (hold_cnt == HOLD_W'(HOLDOFF - 1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset parks the pointer so port 0 wins first
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            ptr              <= PROC_ID_W'(N_PROC - 1);
            cur_src          <= '0;
            cur_dst          <= '0;
            master_response  <= '0;
            data_from_router <= '0;
            busy             <= 1'b0;
            hold_cnt         <= '0;
        end else begin
            state            <= state_n;
            ptr              <= ptr_n;
            cur_src          <= src_n;
            cur_dst          <= dst_n;
            master_response  <= resp_n;
            data_from_router <= dfr_n;
            busy             <= busy_n;
            hold_cnt         <= hold_n;
        end
    end

`ifdef NOC_MASTER_TIMEOUT_EN
    // Stream watchdog counter and its abort pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= tcnt_n;
            timeout_err <= terr_n;
        end
    end
`endif

endmodule

// File: tb/tb_noc_master_arbiter.sv
// Directed testbench for noc_master_arbiter (4 processors, HOLDOFF=2).
// With NOC_MASTER_TIMEOUT_EN the DUT is built with TIMEOUT_CYC=10.
module tb_noc_master_arbiter;
    import noc_pkg::*;

`ifdef NOC_MASTER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 10;
`else
    localparam int TB_TIMEOUT = 300;
`endif

    logic        clock;
    logic        reset;
    logic [3:0]  request_transfer;
    logic [7:0]  which_processor;
    logic [35:0] data_to_router;
    logic [3:0]  master_response;
    logic [35:0] data_from_router;
    logic        busy;
    logic [1:0]  cur_src;
    logic [1:0]  cur_dst;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    noc_master_arbiter #(
        .N_PROC      (4),
        .HOLDOFF     (2),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .request_transfer (request_transfer),
        .which_processor  (which_processor),
        .data_to_router   (data_to_router),
        .master_response  (master_response),
        .data_from_router (data_from_router),
        .busy             (busy),
        .cur_src          (cur_src),
        .cur_dst          (cur_dst),
        .timeout_err      (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [35:0] routed(input int dst, input logic [8:0] flit);
        logic [35:0] v;
        v = '0;
        v[9*dst +: 9] = flit;
        return v;
    endfunction

    task automatic applyStimulus(input logic [3:0] req, input logic [7:0] dst_map);
        request_transfer = req;
        which_processor  = dst_map;
    endtask

    task automatic setFlit(input int p, input logic [8:0] f);
        data_to_router[9*p +: 9] = f;
    endtask

    // Wait for the grant, stream nflits (last on the final one), then ride out RELEASE
    task automatic runTransfer(input string tag, input int src, input int dst, input int nflits,
                               input logic [7:0] base, input bit drop_req);
        int waited;
        logic [3:0] onehot;
        logic [8:0] f;
        waited = 0;
        onehot = 4'b0001 << src;
        while (master_response == 4'b0000 && waited < 16) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_grant"}, 64'(master_response), 64'(onehot));
        checkOutput({tag, "_src"}, 64'(cur_src), 64'(src));
        checkOutput({tag, "_dst"}, 64'(cur_dst), 64'(dst));
        checkOutput({tag, "_busy_grant"}, 64'(busy), 64'd1);
        checkOutput({tag, "_dfr_grant"}, 64'(data_from_router), 64'd0);
        if (drop_req) request_transfer[src] = 1'b0;
        tick();
        checkOutput({tag, "_grant_pulse"}, 64'(master_response), 64'd0);
        for (int k = 0; k < nflits; k++) begin
            f = {(k == nflits - 1), base + 8'(k)};
            setFlit(src, f);
            tick();
            checkOutput({tag, "_flit"}, 64'(data_from_router), 64'(routed(dst, f)));
        end
        setFlit(src, 9'h000);
        checkOutput({tag, "_busy_rel0"}, 64'(busy), 64'd1);
        tick();
        checkOutput({tag, "_dfr_rel"}, 64'(data_from_router), 64'd0);
        checkOutput({tag, "_busy_rel1"}, 64'(busy), 64'd1);
        tick();
        checkOutput({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit saw_terr;
        reset            = 1'b0;
        request_transfer = '0;
        which_processor  = '0;
        data_to_router   = '0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_resp", 64'(master_response), 64'd0);
        checkOutput("rst_dfr", 64'(data_from_router), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_src", 64'(cur_src), 64'd0);
        checkOutput("rst_dst", 64'(cur_dst), 64'd0);
        checkOutput("rst_terr", 64'(timeout_err), 64'd0);
        reset = 1'b1;
        tick();
        checkOutput("post_rst_busy", 64'(busy), 64'd0);

        // First request: P0 -> 2, single-flit burst
        $display("[TB] test 1: first grant");
        applyStimulus(4'b0001, 8'b00_00_00_10);
        runTransfer("t1", 0, 2, 1, 8'hAA, 1'b1);

        // P1 -> P3, five flits; busy falls three cycles after the last flit is presented
        $display("[TB] test 2: five-flit burst");
        applyStimulus(4'b0010, 8'b00_00_11_00);
        runTransfer("t2", 1, 3, 5, 8'h10, 1'b1);

        // Park the pointer on 3 with a P3 transfer, then hold all four requests
        $display("[TB] test 3: round-robin with all requesting");
        applyStimulus(4'b1000, 8'b00_00_00_00);
        runTransfer("t3_prep", 3, 0, 2, 8'h20, 1'b1);
        applyStimulus(4'b1111, 8'b00_11_10_01);
        runTransfer("t3_g0", 0, 1, 2, 8'h30, 1'b0);
        runTransfer("t3_g1", 1, 2, 2, 8'h34, 1'b0);
        runTransfer("t3_g2", 2, 3, 2, 8'h38, 1'b0);
        runTransfer("t3_g3", 3, 0, 2, 8'h3C, 1'b0);
        runTransfer("t3_g0b", 0, 1, 3, 8'h70, 1'b0);
        request_transfer = '0;

        // P2 loopback while P0 waits with noise on its data lane
        $display("[TB] test 4: loopback with a waiting requester");
        applyStimulus(4'b0101, 8'b00_10_00_01);
        setFlit(0, 9'h055);
        runTransfer("t4_loop", 2, 2, 3, 8'h40, 1'b1);
        runTransfer("t4_p0", 0, 1, 2, 8'h60, 1'b1);

        // Reset asserted mid-STREAM at flit 3
        $display("[TB] test 5: reset mid-burst");
        applyStimulus(4'b1000, 8'b01_00_00_00);
        tick();
        checkOutput("t5_grant", 64'(master_response), 64'b1000);
        request_transfer = '0;
        tick();
        setFlit(3, 9'h031);
        tick();
        checkOutput("t5_flit1", 64'(data_from_router), 64'(routed(1, 9'h031)));
        setFlit(3, 9'h032);
        tick();
        checkOutput("t5_flit2", 64'(data_from_router), 64'(routed(1, 9'h032)));
        setFlit(3, 9'h033);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_rst_dfr", 64'(data_from_router), 64'd0);
        checkOutput("t5_rst_busy", 64'(busy), 64'd0);
        checkOutput("t5_rst_resp", 64'(master_response), 64'd0);
        applyStimulus(4'b1010, 8'b01_00_10_00);
        setFlit(3, 9'h000);
        tick();
        tick();
        checkOutput("t5_hold_dfr", 64'(data_from_router), 64'd0);
        reset = 1'b1;
        runTransfer("t5_after", 1, 2, 2, 8'h50, 1'b1);
        request_transfer = '0;

        // Burst that never sends a last flit
        $display("[TB] test 6: missing last flit");
        applyStimulus(4'b0001, 8'b00_00_00_11);
        tick();
        checkOutput("t6_grant", 64'(master_response), 64'b0001);
        request_transfer = '0;
        setFlit(0, 9'h0AB);
        tick();
`ifdef NOC_MASTER_TIMEOUT_EN
        saw_terr = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (timeout_err) saw_terr = 1'b1;
        end
        checkOutput("t6_c9_dfr", 64'(data_from_router), 64'(routed(3, 9'h0AB)));
        checkOutput("t6_c9_terr", 64'(saw_terr), 64'd0);
        tick();
        checkOutput("t6_forced", 64'(data_from_router), 64'(routed(3, 9'h100)));
        checkOutput("t6_terr", 64'(timeout_err), 64'd1);
        tick();
        checkOutput("t6_terr_pulse", 64'(timeout_err), 64'd0);
        checkOutput("t6_rel_dfr", 64'(data_from_router), 64'd0);
        checkOutput("t6_rel_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("t6_idle", 64'(busy), 64'd0);
        setFlit(0, 9'h000);
`else
        saw_terr = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (timeout_err) saw_terr = 1'b1;
        end
        checkOutput("t6_c400_busy", 64'(busy), 64'd1);
        checkOutput("t6_c400_dfr", 64'(data_from_router), 64'(routed(3, 9'h0AB)));
        checkOutput("t6_c400_terr", 64'(saw_terr), 64'd0);
        setFlit(0, 9'h1AB);
        tick();
        checkOutput("t6_last", 64'(data_from_router), 64'(routed(3, 9'h1AB)));
        setFlit(0, 9'h000);
        tick();
        tick();
        checkOutput("t6_idle", 64'(busy), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
